// File: rtl/wb_rr_arbiter.sv
// Four-master round-robin Wishbone arbiter: one owner per cyc envelope, responses routed to the owner.
// Optional stall watchdog compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    // master side
    input  logic [3:0]   m_cyc_i,
    input  logic [3:0]   m_stb_i,
    input  logic [3:0]   m_we_i,
    input  logic [127:0] m_adr_i,
    input  logic [127:0] m_dat_i,
    input  logic [15:0]  m_sel_i,
    output logic [31:0]  m_dat_o,
    output logic [3:0]   m_ack_o,
    output logic [3:0]   m_err_o,
    // slave side
    output logic         s_cyc_o,
    output logic         s_stb_o,
    output logic         s_we_o,
    output logic [31:0]  s_adr_o,
    output logic [31:0]  s_dat_o,
    output logic [3:0]   s_sel_o,
    input  logic [31:0]  s_dat_i,
    input  logic         s_ack_i,
    input  logic         s_err_i,
    // sideband
    output logic [3:0]   gnt_o,
    output logic         busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_rr_arbiter: TIMEOUT_CYCLES must lie in 1..65535");
    end

    state_t     state, state_nxt;
    logic [1:0] last, last_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       pick_valid;
    logic       owning;
    logic       timeout;

    // While owning, the owner is always the most recent winner, so `last` doubles as the owner index.
    logic        own_cyc;
    logic        own_stb;
    logic        own_we;
    logic [31:0] own_adr;
    logic [31:0] own_dat;
    logic [3:0]  own_sel;

    assign owning  = (state == OWN);
    assign own_cyc = m_cyc_i[last];
    assign own_stb = m_stb_i[last];
    assign own_we  = m_we_i[last];
    assign own_adr = m_adr_i[{last, 5'd0} +: 32];
    assign own_dat = m_dat_i[{last, 5'd0} +: 32];
    assign own_sel = m_sel_i[{last, 2'd0} +: 4];

    // Scan offsets 4 down to 1 so the smallest offset from last+1 is the final, winning assignment.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise synthesis infers latches.
        pick       = 2'd0;
        cand       = 2'd0;
        pick_valid = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (m_cyc_i[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        gnt_nxt   = gnt_o;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = OWN;
                    last_nxt  = pick;
                    gnt_nxt   = 4'b0001 << pick;
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
            last  <= 2'd3;
            gnt_o <= 4'b0000;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            gnt_o <= gnt_nxt;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        stalled;

    assign stalled = owning & own_stb & ~s_ack_i & ~s_err_i;
    assign timeout = stalled & (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    // The firing cycle is itself the TIMEOUT_CYCLES-th stalled strobe; a strobe gap holds the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= 16'd0;
        end else if (!owning || !own_cyc || timeout) begin
            wd_cnt <= 16'd0;
        end else if (stalled) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else if (own_stb) begin
            wd_cnt <= 16'd0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign busy_o  = owning;
    assign s_cyc_o = owning & own_cyc & ~timeout;
    assign s_stb_o = owning & own_stb & ~timeout;
    assign s_we_o  = owning & own_we;
    assign s_adr_o = owning ? own_adr : 32'd0;
    assign s_dat_o = owning ? own_dat : 32'd0;
    assign s_sel_o = owning ? own_sel : 4'd0;

    // gnt_o is zero outside OWN, so it masks stray slave terminations while idle.
    assign m_dat_o = s_dat_i;
    assign m_ack_o = gnt_o & {4{s_ack_i & s_stb_o}};
    assign m_err_o = gnt_o & {4{(s_err_i & s_stb_o) | timeout}};

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Four-master round-robin Wishbone arbiter that shares one slave port, typically a conbus slave slot or a single shared peripheral, between requesters. Requesters include LM32 instruction and data ports, a DMA engine, or a debug bridge. It grants ownership per Wishbone cycle (`cyc` envelope), routes handshakes back to the owner only, and reports ownership on sideband outputs. An optional watchdog terminates stalled cycles with a bus error.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: watchdog limit in clocks of unacknowledged strobe (1..65535); only used with the watchdog compiled in.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m_cyc_i`  in  4  per-master cycle request; bit k = master k.
- `m_stb_i`  in  4  per-master strobe.
- `m_we_i`  in  4  per-master write enable.
- `m_adr_i`  in  128  master k address at [32k+31:32k].
- `m_dat_i`  in  128  master k write data at [32k+31:32k].
- `m_sel_i`  in  16  master k byte selects at [4k+3:4k].
- `m_dat_o`  out  32  slave read data, broadcast to all masters.
- `m_ack_o`  out  4  ack, owner bit only.
- `m_err_o`  out  4  error, owner bit only.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  muxed slave controls.
- `s_adr_o`  out  32  muxed address.
- `s_dat_o`  out  32  muxed write data.
- `s_sel_o`  out  4  muxed byte selects.
- `s_dat_i`  in  32  slave read data.
- `s_ack_i`, `s_err_i`  in  1  slave termination.
- `gnt_o`  out  4  one-hot current owner, registered.
- `busy_o`  out  1  high in OWN state.

## Operation
- FSM states: IDLE, OWN.
- IDLE: if `m_cyc_i` is nonzero, select the first requester scanning from `last+1` mod 4 upward. Register `gnt_o`, update `last`, go to OWN. Otherwise stay in IDLE.
- OWN: hold the grant while the owner's `m_cyc_i` is high. When the owner's `cyc` goes low, go to IDLE and clear `gnt_o`. Requests from other masters never preempt the owner.
- Slave outputs in OWN: `s_cyc_o = m_cyc_i[own]`; `s_stb_o = m_stb_i[own]`; `we/adr/dat/sel` come from the owner slice.
- Slave outputs in IDLE: `s_cyc_o = s_stb_o = 0`; `adr/dat/sel/we` are driven 0.
- Response routing: `m_ack_o[own] = s_ack_i & s_stb_o`; `m_err_o[own] = s_err_i & s_stb_o`. All other bits are 0. `m_dat_o = s_dat_i` always.
- Simultaneous requests resolve by the round-robin pointer only. Example: with `last`=1 and requests 0,2,3 pending, master 2 wins.
- A master that drops `cyc` and re-raises it in the following cycle competes normally; it gets no priority.
- `s_ack_i` or `s_err_i` arriving in IDLE is ignored.

## Timing
- Reset values: state IDLE, `gnt_o`=0, `busy_o`=0, `last`=3 (master 0 wins first), watchdog count 0. All `s_*` control outputs and `m_ack_o`/`m_err_o` are 0.
- Grant latency: a request in cycle T produces `s_cyc_o` in cycle T+1.
- Release: owner `cyc` low in cycle T gives IDLE in T+1. The next grant is visible in T+2, so there is exactly one dead cycle between owners.
- The response path is combinational from slave to master, adding zero cycles. The request path after grant is combinational.
- `rst_n` asserted mid-cycle: all outputs go to reset values immediately (async). The in-flight transfer is abandoned and no ack is forwarded.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined: a 16-bit counter increments each OWN cycle with `s_stb_o`=1 and no `s_ack_i`/`s_err_i`. It clears on any termination or on leaving OWN.
  - When the count reaches `TIMEOUT_CYCLES`, the arbiter drives `m_err_o[own]`=1 for exactly one cycle.
  - In that same cycle it forces `s_cyc_o`=`s_stb_o`=0, then clears the counter.
  - The grant is retained until the owner drops `cyc`.
- Macro undefined: no counter exists, and stalled cycles wait indefinitely.

## Test plan
- Single request: master 2 raises `cyc/stb` with adr 0x40000004. Expect `gnt_o`=0100 and `s_adr_o`=0x40000004 one clock later. Slave acks, so `m_ack_o`=0100 in the same cycle.
- Simultaneous requests after reset: all four `cyc` held high, each owner drops `cyc` after one ack. Expect grant order 0,1,2,3,0 with exactly one idle cycle between grants.
- No preemption: master 1 owns and holds `cyc` for 10 acks while master 0 requests. Expect master 0 granted only after master 1 releases, and `m_ack_o[0]` stays 0 throughout.
- Error routing: the slave returns `s_err_i` to owner 3. Expect `m_err_o`=1000 and `m_ack_o`=0000.
- Watchdog with `WB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8: the slave never acks. Expect a one-cycle `m_err_o[own]` pulse on the 8th stalled cycle and `s_stb_o` low in that cycle. Without the macro, no error pulse appears within 1000 cycles.
- Reset mid-transfer: assert `rst_n`=0 while master 1 owns. Expect `gnt_o`=0 and `s_cyc_o`=0 without waiting for a clock. After release, the first grant goes to master 0 when all masters request.
